free_memory: RTL and testbench

FREE_MEMORY -- requirements
Module: free_memory

---
 rtl/memory_pkg.sv | 21 ++
 rtl/free_memory.sv | 100 ++++++++++
 tb/tb_free_memory.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the slot allocator / free-er pair working on one RAM.
// Holds the slot layout constants, error codes and free-controller states.
package memory_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int SLOT_WORDS = 32;
  localparam int USED_BIT   = 31;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_MISALIGNED  = 2'd1;
  localparam logic [1:0] ERR_ZERO        = 2'd2;
  localparam logic [1:0] ERR_DOUBLE_FREE = 2'd3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_READ_HDR = 3'd1;
  localparam logic [2:0] ST_WAIT_HDR = 3'd2;
  localparam logic [2:0] ST_CLEAR    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/free_memory.sv
// Frees one RAM slot: checks the header used flag, then zeroes the slot top-down
// so the header is cleared last; bad or already-free requests end without writes.
module free_memory #(
  parameter int ADDR_W     = memory_pkg::ADDR_W,
  parameter int SLOT_WORDS = memory_pkg::SLOT_WORDS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             free_addr,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    err_code,
  output logic [ADDR_W-1:0]             ram_address,
  output logic [memory_pkg::DATA_W-1:0] ram_data,
  output logic                          ram_wren,
  input  logic [memory_pkg::DATA_W-1:0] ram_q
);
  import memory_pkg::*;

  localparam int OFF_W = $clog2(SLOT_WORDS);

  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic [OFF_W-1:0]  cnt;
  logic [1:0]        code;
  logic [OFF_W-1:0]  cnt_dec;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] top_addr;
  logic              unused_q;

  assign cnt_dec  = cnt - 1'b1;
  // Offsets never carry into the base because the base is slot aligned.
  assign clr_addr = base | ADDR_W'(cnt_dec);
  assign top_addr = base | ADDR_W'({OFF_W{1'b1}});
  assign unused_q = ^ram_q[USED_BIT-1:0];

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign error    = done && (code != ERR_NONE);
  assign err_code = done ? code : ERR_NONE;
  assign ram_wren = (state == ST_CLEAR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      base        <= '0;
      cnt         <= '0;
      code        <= ERR_NONE;
      ram_address <= '0;
      ram_data    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (|free_addr[OFF_W-1:0]) begin
              code  <= ERR_MISALIGNED;
              state <= ST_DONE;
            end else if (free_addr == '0) begin
              code  <= ERR_ZERO;
              state <= ST_DONE;
            end else begin
              code        <= ERR_NONE;
              base        <= free_addr;
              ram_address <= free_addr;
              state       <= ST_READ_HDR;
            end
          end
        end
        ST_READ_HDR: state <= ST_WAIT_HDR;
        ST_WAIT_HDR: begin
          if (ram_q[USED_BIT]) begin
            cnt         <= '1;
            ram_address <= top_addr;
            ram_data    <= '0;
            state       <= ST_CLEAR;
          end else begin
            code  <= ERR_DOUBLE_FREE;
            state <= ST_DONE;
          end
        end
        ST_CLEAR: begin
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            cnt         <= cnt_dec;
            ram_address <= clr_addr;
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_free_memory.sv
// Bench for free_memory: 1-cycle-latency RAM model, directed scenarios, then
// random requests checked against a slot-level reference of the memory.
module tb_free_memory;
  localparam int AW    = 10;
  localparam int SW    = 32;
  localparam int DEPTH = 1 << AW;
  localparam int LOGN  = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] free_addr = '0;
  logic          busy, done, error, ram_wren;
  logic [1:0]    err_code;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data;
  logic [31:0]   ram_q = '0;

  logic [31:0]   mem     [DEPTH];
  logic [31:0]   ref_mem [DEPTH];
  logic [AW-1:0] wr_addr [LOGN];
  int            wr_n    = 0;
  int            nz_data = 0;

  logic          fill   = 1'b0;
  logic          bd_vld = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_dat  = '0;

  int n_err    = 0;
  int n_checks = 0;

  free_memory #(.ADDR_W(AW), .SLOT_WORDS(SW)) dut (
    .clock(clock), .reset(reset), .start(start), .free_addr(free_addr),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Single process owns the RAM array: preload, backdoor pokes, DUT port.
  always @(posedge clock) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (bd_vld) begin
      mem[bd_addr] <= bd_dat;
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
      if (wr_n < LOGN) wr_addr[wr_n] <= ram_address;
      wr_n <= wr_n + 1;
      if (ram_data != 32'h0) nz_data <= nz_data + 1;
    end
    ram_q <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [31:0] v);
    bd_addr = a; bd_dat = v; bd_vld = 1'b1;
    ref_mem[a] = v;
    @(posedge clock); #1;
    bd_vld = 1'b0;
  endtask

  // Reference: decides outcome from slot rules and applies the effect to ref_mem.
  task automatic model(input logic [AW-1:0] a, output int lat, output logic [1:0] code, output int nwr);
    int ai;
    ai = int'(a);
    if (ai % SW != 0) begin
      code = 2'd1; lat = 1; nwr = 0;
    end else if (ai == 0) begin
      code = 2'd2; lat = 1; nwr = 0;
    end else if (ref_mem[ai][31] == 1'b0) begin
      code = 2'd3; lat = 3; nwr = 0;
    end else begin
      code = 2'd0; lat = 2 + SW + 1; nwr = SW;
      for (int i = 0; i < SW; i++) ref_mem[ai + i] = 32'h0;
    end
  endtask

  function automatic int order_errs(input int first, input int base);
    int e;
    e = 0;
    for (int i = 0; i < SW; i++)
      if (int'(wr_addr[first + i]) != base + SW - 1 - i) e++;
    return e;
  endfunction

  // Issues one request starting between edges; returns measured latency and outcome.
  task automatic run_req(input logic [AW-1:0] a, output int lat, output logic err, output logic [1:0] code);
    start = 1'b1; free_addr = a;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    err  = error;
    code = err_code;
    @(posedge clock); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic req_and_check(input string tag, input logic [AW-1:0] a);
    int exp_lat, exp_nwr, lat, w0;
    logic [1:0] exp_code, code;
    logic err;
    w0 = wr_n;
    model(a, exp_lat, exp_code, exp_nwr);
    run_req(a, lat, err, code);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_error"}, 32'(err), 32'(exp_code != 2'd0));
    check({tag, "_err_code"}, 32'(code), 32'(exp_code));
    check({tag, "_n_writes"}, 32'(wr_n - w0), 32'(exp_nwr));
    if (exp_nwr == SW)
      check({tag, "_write_order"}, 32'(order_errs(w0, int'(a))), 32'd0);
  endtask

  initial begin
    int g, w0, lat, mism;
    logic [AW-1:0] a, addr_before;
    logic [1:0] code, exp_code;
    logic err;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    fill = 1'b1;
    @(posedge clock); #1;
    fill = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_address", 32'(ram_address), 32'd0);
    check("rst_data", ram_data, 32'd0);

    poke(AW'(64), 32'h8000_0000);
    poke(AW'(128), 32'h0000_0000);
    @(negedge clock); reset = 1'b0;

    // Free a used slot on the first edge after reset.
    req_and_check("slot64", AW'(64));
    check("slot64_header", mem[64], 32'h0);
    check("slot64_top", mem[95], 32'h0);

    req_and_check("misaligned70", AW'(70));

    addr_before = ram_address;
    req_and_check("addr_zero", AW'(0));
    check("addr_zero_no_addr", 32'(ram_address), 32'(addr_before));

    req_and_check("double_free128", AW'(128));
    check("double_free_read_addr", 32'(ram_address), 32'd128);

    // Reset in the middle of clearing slot 64.
    for (int i = 0; i < SW; i++) poke(AW'(64 + i), 32'(i + 1));
    poke(AW'(64), 32'h8000_0000);
    w0 = wr_n;
    start = 1'b1; free_addr = AW'(64);
    @(posedge clock); #1;
    start = 1'b0;
    g = 0;
    while (!ram_wren && g < 20) begin @(posedge clock); #1; g++; end
    check("rst_mid_wren_seen", 32'(ram_wren), 32'd1);
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_wren", 32'(ram_wren), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_n_writes", 32'(wr_n - w0), 32'd10);
    check("rst_mid_header", mem[64], 32'h8000_0000);
    for (int i = 86; i < 96; i++) ref_mem[i] = 32'h0;
    @(negedge clock); reset = 1'b0;

    // Second start while busy must be ignored.
    poke(AW'(96), 32'h8000_0000);
    poke(AW'(160), 32'h8000_00AA);
    w0 = wr_n;
    model(AW'(96), lat, exp_code, g);
    start = 1'b1; free_addr = AW'(96);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1 start = 1'b1; free_addr = AW'(160);
    @(posedge clock); #1;
    start = 1'b0;
    g = 0;
    while (!done && g < 100) begin @(posedge clock); #1; g++; end
    check("ignore_done", 32'(done), 32'd1);
    check("ignore_error", 32'(error), 32'd0);
    @(posedge clock); #1;
    check("ignore_n_writes", 32'(wr_n - w0), 32'(SW));
    check("ignore_order", 32'(order_errs(w0, 96)), 32'd0);
    check("ignore_slot160", mem[160], 32'h8000_00AA);
    check("ignore_stays_idle", 32'(busy), 32'd0);

    // Random requests against the reference.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: a = AW'($urandom_range(0, 31) * SW + $urandom_range(1, SW - 1));
        1: a = AW'(0);
        default: begin
          a = AW'($urandom_range(1, 31) * SW);
          if ($urandom_range(0, 1) == 1) poke(a, ref_mem[a] | 32'h8000_0000);
        end
      endcase
      req_and_check("rand", a);
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("ram_image", 32'(mism), 32'd0);
    check("nonzero_write_data", 32'(nz_data), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
